// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared encodings and default sizes for the branch predictor.
package branch_predictor_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_TAG_BITS   = 8;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/bp_table.sv
// bp_table: entry storage with a combinational lookup port, a training write port and a clear port.
module bp_table import branch_predictor_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [ADDR_WIDTH-1:0] rd_target,
  output ctr_t                  rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic                  wr_taken,
  input  logic [ADDR_WIDTH-1:0] wr_target,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_idx
);
  localparam int ENTRIES = 2**INDEX_BITS;
  logic                  valid  [ENTRIES];
  logic [TAG_BITS-1:0]   tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target [ENTRIES];
  ctr_t                  ctr    [ENTRIES];
  logic wr_hit;
  ctr_t wr_ctr, next_ctr;
  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag[rd_idx];
  assign rd_target = target[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  assign wr_hit    = valid[wr_idx] && tag[wr_idx] == wr_tag;
  assign wr_ctr    = ctr[wr_idx];
  assign next_ctr  = wr_taken ? (wr_ctr == ST ? ST : ctr_t'(wr_ctr + 2'd1))
                              : (wr_ctr == SNT ? SNT : ctr_t'(wr_ctr - 2'd1));
  // a hit trains the counter; a taken miss allocates, evicting whatever aliased there
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid[clr_idx] <= 1'b0;
      ctr[clr_idx]   <= WNT;
    end else if (wr_en && (wr_hit || wr_taken)) begin
      valid[wr_idx] <= 1'b1;
      tag[wr_idx]   <= wr_tag;
      ctr[wr_idx]   <= wr_hit ? next_ctr : WT;
      if (wr_taken) target[wr_idx] <= wr_target;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, init sweep after reset and perf counters.
module branch_predictor import branch_predictor_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_en,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic                  ready,
  input  logic                  upd_en,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           miss_cnt
);
  state_t                state;
  logic [INDEX_BITS-1:0] init_idx;
  logic                  rd_valid, accept, unused;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [ADDR_WIDTH-1:0] rd_target;
  ctr_t                  rd_ctr;
  assign accept      = upd_en & ready;
  assign pred_hit    = ready & lookup_en & rd_valid & (rd_tag == lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
  assign pred_taken  = pred_hit & rd_ctr[1];
  assign pred_target = pred_taken ? rd_target : lookup_pc + ADDR_WIDTH'(4);
  assign unused      = ^{upd_pc, rd_ctr};
  bp_table #(.ADDR_WIDTH(ADDR_WIDTH), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_table (
    .clk       (clk),
    .rd_idx    (lookup_pc[INDEX_BITS+1:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .wr_en     (accept),
    .wr_idx    (upd_pc[INDEX_BITS+1:2]),
    .wr_tag    (upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]),
    .wr_taken  (upd_taken),
    .wr_target (upd_target),
    .clr_en    (state == INIT),
    .clr_idx   (init_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_idx   <= '0;
      ready      <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + INDEX_BITS'(1);
      if (&init_idx) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else if (accept) begin
      branch_cnt <= branch_cnt + 32'(~&branch_cnt);
      miss_cnt   <= miss_cnt + 32'(upd_mispredict & ~&miss_cnt);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table, reset/init sequences and a randomized run against a BTB model.
module tb_branch_predictor;
  logic        clk = 0, rst = 1, lookup_en = 0, upd_en = 0, upd_taken = 0, upd_mispredict = 0;
  logic [31:0] lookup_pc = 0, upd_pc = 0, upd_target = 0;
  logic        pred_hit, pred_taken, ready;
  logic [31:0] pred_target, branch_cnt, miss_cnt;
  int          errors = 0, checks = 0, exp_br = 0, exp_ms = 0;
  typedef struct {
    logic len; logic [31:0] lpc; logic uen; logic [31:0] upc; logic ut; logic [31:0] utg; logic um;
    logic hit; logic tk; logic [31:0] tg;
  } vec_t;
  vec_t vecs[$];
  logic        mv[64];
  logic [7:0]  mt[64];
  logic [31:0] mtg[64];
  int          mc[64];

  branch_predictor dut (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target), .ready(ready),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic len, input logic [31:0] lpc, input logic uen, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utg, input logic um,
                     input logic hit, input logic tk, input logic [31:0] tg);
    vec_t v;
    v.len = len; v.lpc = lpc; v.uen = uen; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um;
    v.hit = hit; v.tk = tk; v.tg = tg;
    vecs.push_back(v);
  endtask

  task automatic lookup_chk(input string nm, input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tg);
    lookup_en = 1; lookup_pc = pc;
    #1;
    chk({nm, " hit"}, pred_hit, hit);
    chk({nm, " taken"}, pred_taken, tk);
    chk({nm, " target"}, pred_target, tg);
  endtask

  initial begin
    add(1, 32'h40, 1, 32'h40, 1, 32'h100, 1, 0, 0, 32'h44);
    add(1, 32'h40, 1, 32'h40, 0, 32'h0,   1, 1, 1, 32'h100);
    add(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 0, 32'h44);
    add(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h44);
    add(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 1, 32'h100);
    for (int i = 0; i < 3; i++) add(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 1, 32'h100);
    add(1, 32'h40, 1, 32'h40, 0, 32'h999, 0, 1, 1, 32'h100);
    add(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    add(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h144);
    add(1, 32'h140, 1, 32'h140, 1, 32'h200, 1, 0, 0, 32'h144);
    add(1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h44);
    add(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200);
    add(1, 32'h80, 1, 32'h80, 1, 32'h300, 1, 0, 0, 32'h84);
    add(1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h300);
    add(0, 32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h84);
    add(1, 32'hC0, 1, 32'hC0, 0, 32'h500, 1, 0, 0, 32'hC4);
    add(1, 32'hC0, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'hC4);
    add(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);

    // power-up reset, then an update during the init sweep that must be dropped
    tick; tick;
    chk("reset ready", ready, 0);
    chk("reset branch_cnt", branch_cnt, 0);
    chk("reset miss_cnt", miss_cnt, 0);
    lookup_chk("reset lookup", 32'h40, 0, 0, 32'h44);
    rst = 0;
    upd_en = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100; upd_mispredict = 1;
    for (int e = 1; e <= 64; e++) begin
      tick;
      if (e >= 62) chk($sformatf("init ready edge %0d", e), ready, e == 64);
      else if (ready) chk($sformatf("init ready early edge %0d", e), ready, 0);
    end
    upd_en = 0;
    lookup_chk("init dropped update", 32'h40, 0, 0, 32'h44);
    chk("init branch_cnt", branch_cnt, 0);
    chk("init miss_cnt", miss_cnt, 0);

    foreach (vecs[i]) begin
      lookup_en = vecs[i].len; lookup_pc = vecs[i].lpc;
      upd_en = vecs[i].uen; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_target = vecs[i].utg; upd_mispredict = vecs[i].um;
      #1;
      chk($sformatf("vec%0d hit", i), pred_hit, vecs[i].hit);
      chk($sformatf("vec%0d taken", i), pred_taken, vecs[i].tk);
      chk($sformatf("vec%0d target", i), pred_target, vecs[i].tg);
      exp_br += int'(vecs[i].uen);
      exp_ms += int'(vecs[i].uen & vecs[i].um);
      tick;
    end
    upd_en = 0;
    chk("vec branch_cnt", branch_cnt, exp_br);
    chk("vec miss_cnt", miss_cnt, exp_ms);

    // reset while running restarts the sweep and forgets every entry
    rst = 1;
    tick;
    rst = 0;
    chk("midrst ready", ready, 0);
    chk("midrst branch_cnt", branch_cnt, 0);
    chk("midrst miss_cnt", miss_cnt, 0);
    repeat (63) tick;
    chk("midrst ready edge 63", ready, 0);
    tick;
    chk("midrst ready edge 64", ready, 1);
    lookup_chk("midrst lookup 0x40", 32'h40, 0, 0, 32'h44);
    lookup_chk("midrst lookup 0x80", 32'h80, 0, 0, 32'h84);

    exp_br = 0; exp_ms = 0;
    for (int i = 0; i < 64; i++) begin mv[i] = 0; mt[i] = 0; mtg[i] = 0; mc[i] = 1; end
    for (int n = 0; n < 400; n++) begin
      int li, ui;
      logic eh, et;
      logic [31:0] etg;
      lookup_en = ($urandom_range(0, 7) != 0);
      lookup_pc = $urandom & 32'hFFFF_031C;
      upd_en = $urandom_range(0, 1);
      upd_pc = (($urandom_range(0, 3) == 0) ? lookup_pc : $urandom) & 32'hFFFF_031C;
      upd_taken = $urandom_range(0, 1);
      upd_target = $urandom & 32'hFFFF_FFFC;
      upd_mispredict = $urandom_range(0, 1);
      li = int'(lookup_pc[7:2]);
      eh = lookup_en && mv[li] && mt[li] == lookup_pc[15:8];
      et = eh && mc[li] >= 2;
      etg = et ? mtg[li] : lookup_pc + 32'd4;
      #1;
      chk($sformatf("rand%0d hit", n), pred_hit, eh);
      chk($sformatf("rand%0d taken", n), pred_taken, et);
      chk($sformatf("rand%0d target", n), pred_target, etg);
      tick;
      if (upd_en) begin
        ui = int'(upd_pc[7:2]);
        exp_br++;
        if (upd_mispredict) exp_ms++;
        if (mv[ui] && mt[ui] == upd_pc[15:8]) begin
          mc[ui] = upd_taken ? (mc[ui] < 3 ? mc[ui] + 1 : 3) : (mc[ui] > 0 ? mc[ui] - 1 : 0);
          if (upd_taken) mtg[ui] = upd_target;
        end else if (upd_taken) begin
          mv[ui] = 1; mt[ui] = upd_pc[15:8]; mtg[ui] = upd_target; mc[ui] = 2;
        end
      end
    end
    upd_en = 0;
    chk("rand branch_cnt", branch_cnt, exp_br);
    chk("rand miss_cnt", miss_cnt, exp_ms);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
